// File: rtl/segment_scan_hex_decoder.sv
// Reverse-decodes a scanned, active-low 7-segment bus into per-digit hex values with blank/undefined flags.
// Digit outputs land STABLE_CYCLES edges after the input register; no backpressure. Letters A-F need SEGMENT_SCAN_HEX_LETTERS_EN.
module segment_scan_hex_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  Clk,
  input  logic                  nReset,
  input  logic [6:0]            Segments,
  input  logic [DIGITS-1:0]     Anodes,
  output logic [4*DIGITS-1:0]   HexDigits,
  output logic [DIGITS-1:0]     Undefined,
  output logic [DIGITS-1:0]     Blank,
  output logic                  Valid,
  output logic                  FrameStrobe,
  output logic                  Changed
);

  localparam int         KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [6:0]        seg_q, prev_seg;
  logic [DIGITS-1:0] an_q;
  logic [KW-1:0]     k, prev_k;
  logic [4:0]        low_cnt;
  logic              legal, same, capture;
  logic [7:0]        cnt, cnt_nxt;
  logic [DIGITS-1:0] seen, seen_set;
  logic [5:0]        dec, old;

  // Result packing is {undefined, blank, hex}.
  function automatic logic [5:0] decode(input logic [6:0] g);
    case (g)
      7'b0000001: decode = {2'b00, 4'h0};
      7'b1001111: decode = {2'b00, 4'h1};
      7'b0010010: decode = {2'b00, 4'h2};
      7'b0000110: decode = {2'b00, 4'h3};
      7'b1001100: decode = {2'b00, 4'h4};
      7'b0100100: decode = {2'b00, 4'h5};
      7'b0100000: decode = {2'b00, 4'h6};
      7'b0001111: decode = {2'b00, 4'h7};
      7'b0000000: decode = {2'b00, 4'h8};
      7'b0000100: decode = {2'b00, 4'h9};
`ifdef SEGMENT_SCAN_HEX_LETTERS_EN
      7'b0001000: decode = {2'b00, 4'hA};
      7'b1100000: decode = {2'b00, 4'hB};
      7'b0110001: decode = {2'b00, 4'hC};
      7'b1000010: decode = {2'b00, 4'hD};
      7'b0110000: decode = {2'b00, 4'hE};
      7'b0111000: decode = {2'b00, 4'hF};
`endif
      7'b1111111,
      7'b1111110: decode = {2'b01, 4'h0};
      default:    decode = {2'b10, 4'hF};
    endcase
  endfunction

  always_comb begin
    low_cnt  = '0;
    k        = '0;
    old      = '0;
    seen_set = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_q[i]) begin
        low_cnt = low_cnt + 5'd1;
        k       = KW'(i);
      end
    end
    legal = (low_cnt == 5'd1);
    // cnt is nonzero exactly when the previous sample was a legal select.
    same  = (cnt != 8'd0) && (k == prev_k) && (seg_q == prev_seg);
    if (!legal)
      cnt_nxt = 8'd0;
    else if (same)
      cnt_nxt = (cnt == STABLE) ? cnt : cnt + 8'd1;
    else
      cnt_nxt = 8'd1;
    capture = legal && (cnt_nxt == STABLE) && !(same && (cnt == STABLE));
    dec     = decode(seg_q);
    for (int i = 0; i < DIGITS; i++) begin
      if (k == KW'(i)) begin
        old         = {Undefined[i], Blank[i], HexDigits[4*i +: 4]};
        seen_set[i] = capture;
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      seg_q       <= '1;
      an_q        <= '1;
      prev_seg    <= '1;
      prev_k      <= '0;
      cnt         <= '0;
      seen        <= '0;
      HexDigits   <= '0;
      Undefined   <= '1;
      Blank       <= '0;
      Valid       <= 1'b0;
      FrameStrobe <= 1'b0;
      Changed     <= 1'b0;
    end else begin
      seg_q    <= Segments;
      an_q     <= Anodes;
      prev_seg <= seg_q;
      prev_k   <= k;
      cnt      <= cnt_nxt;
      for (int i = 0; i < DIGITS; i++) begin
        if (seen_set[i]) begin
          HexDigits[4*i +: 4] <= dec[3:0];
          Blank[i]            <= dec[4];
          Undefined[i]        <= dec[5];
        end
      end
      Changed     <= capture && (dec != old);
      FrameStrobe <= &seen;
      Valid       <= Valid | (&seen);
      // A capture landing on the clearing cycle keeps its bit.
      seen        <= ((&seen) ? '0 : seen) | seen_set;
    end
  end

endmodule

// File: tb/tb_segment_scan_hex_decoder.sv
// Randomised and directed bench for segment_scan_hex_decoder against a dwell-level reference model.
module tb_segment_scan_hex_decoder;
  localparam int DIGITS = 4;
  localparam int S      = 3;

  logic                Clk = 1'b0;
  logic                nReset;
  logic [6:0]          Segments;
  logic [DIGITS-1:0]   Anodes;
  logic [4*DIGITS-1:0] HexDigits;
  logic [DIGITS-1:0]   Undefined, Blank;
  logic                Valid, FrameStrobe, Changed;

  segment_scan_hex_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .Clk(Clk), .nReset(nReset), .Segments(Segments), .Anodes(Anodes),
    .HexDigits(HexDigits), .Undefined(Undefined), .Blank(Blank),
    .Valid(Valid), .FrameStrobe(FrameStrobe), .Changed(Changed)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0, n_err = 0;
  int dut_chg = 0, dut_strb = 0, exp_chg = 0, exp_strb = 0;

  logic [3:0]        m_hex [DIGITS];
  logic              m_und [DIGITS];
  logic              m_blk [DIGITS];
  logic [DIGITS-1:0] m_seen;
  logic              m_valid;

  // Glyphs for values 0..15 (entries 10..15 are the letters A..F).
  logic [6:0] glyph_of [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  always @(negedge Clk) begin
    if (nReset) begin
      if (Changed)     dut_chg++;
      if (FrameStrobe) dut_strb++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] model_decode(input logic [6:0] g);
    int top;
`ifdef SEGMENT_SCAN_HEX_LETTERS_EN
    top = 16;
`else
    top = 10;
`endif
    if (g == 7'h7F || g == 7'h7E) return {2'b01, 4'h0};
    for (int v = 0; v < top; v++)
      if (g == glyph_of[v]) return {2'b00, 4'(v)};
    return {2'b10, 4'hF};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DIGITS; i++) begin
      m_hex[i] = 4'h0; m_und[i] = 1'b1; m_blk[i] = 1'b0;
    end
    m_seen  = '0;
    m_valid = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller guarantees consecutive dwells differ in digit or glyph.
  task automatic dwell(input logic [DIGITS-1:0] an, input logic [6:0] seg, input int len);
    int kk;
    logic [5:0] d;
    Anodes   = an;
    Segments = seg;
    repeat (len) @(negedge Clk);
    if ($countones(~an) == 1 && len >= S) begin
      kk = 0;
      for (int i = 0; i < DIGITS; i++) if (!an[i]) kk = i;
      d = model_decode(seg);
      if (d != {m_und[kk], m_blk[kk], m_hex[kk]}) exp_chg++;
      m_und[kk] = d[5]; m_blk[kk] = d[4]; m_hex[kk] = d[3:0];
      m_seen[kk] = 1'b1;
      if (&m_seen) begin
        exp_strb++;
        m_valid = 1'b1;
        m_seen  = '0;
      end
    end
  endtask

  task automatic idle(input int n);
    Anodes   = '1;
    Segments = '1;
    repeat (n) @(negedge Clk);
  endtask

  task automatic check_all(input string tag);
    logic [4*DIGITS-1:0] eh;
    logic [DIGITS-1:0]   eu, eb;
    for (int i = 0; i < DIGITS; i++) begin
      eh[4*i +: 4] = m_hex[i]; eu[i] = m_und[i]; eb[i] = m_blk[i];
    end
    check({tag, "_hex"},    32'(HexDigits), 32'(eh));
    check({tag, "_undef"},  32'(Undefined), 32'(eu));
    check({tag, "_blank"},  32'(Blank),     32'(eb));
    check({tag, "_valid"},  32'(Valid),     32'(m_valid));
    check({tag, "_nchg"},   32'(dut_chg),   32'(exp_chg));
    check({tag, "_nstrb"},  32'(dut_strb),  32'(exp_strb));
  endtask

  initial begin
    logic [DIGITS-1:0] an;
    logic [6:0]        g;
    int                len;
    model_reset();
    nReset = 1'b0; Anodes = '1; Segments = '1;
    repeat (3) @(negedge Clk);
    check("rst_hex", 32'(HexDigits), 32'h0);
    check("rst_undef", 32'(Undefined), 32'hF);
    check("rst_pulses", 32'({Valid, FrameStrobe, Changed}), 32'h0);
    nReset = 1'b1;

    idle(50);
    check_all("idle");

    dwell(4'b1110, glyph_of[1], 4);
    dwell(4'b1101, glyph_of[2], 4);
    dwell(4'b1011, glyph_of[3], 4);
    dwell(4'b0111, glyph_of[4], 4);
    idle(3);
    check_all("frame1");
    check("frame1_const", 32'(HexDigits), 32'h4321);
    check("frame1_chg4", 32'(dut_chg), 32'd4);
    check("frame1_strb1", 32'(dut_strb), 32'd1);

    dwell(4'b1110, glyph_of[8], 2);
    dwell(4'b1101, glyph_of[8], 2);
    dwell(4'b1011, glyph_of[8], 2);
    dwell(4'b0111, glyph_of[8], 2);
    idle(3);
    check_all("short");

    dwell(4'b1110, glyph_of[1], 4);
    dwell(4'b1101, glyph_of[2], 4);
    dwell(4'b1011, glyph_of[3], 4);
    dwell(4'b0111, glyph_of[4], 4);
    idle(3);
    check_all("repeat");
    check("repeat_strb2", 32'(dut_strb), 32'd2);

    dwell(4'b1011, 7'b1110000, 4);
    idle(3);
    check_all("undef2");
    check("undef2_const", 32'({Undefined, HexDigits}), 32'h44F21);

    dwell(4'b1100, glyph_of[5], 10);
    idle(3);
    check_all("twolow");

    Anodes = 4'b1110; Segments = glyph_of[8];
    repeat (2) @(negedge Clk);
    #2 nReset = 1'b0;
    #1;
    check("midrst_hex", 32'(HexDigits), 32'h0);
    check("midrst_flags", 32'({Undefined, Blank}), 32'hF0);
    check("midrst_pulses", 32'({Valid, FrameStrobe, Changed}), 32'h0);
    model_reset();
    Anodes = '1; Segments = '1;
    @(negedge Clk);
    nReset = 1'b1;
    idle(3);
    check_all("postrst");

    dwell(4'b1110, 7'b0001000, 4);
    idle(3);
    check_all("letter");
`ifdef SEGMENT_SCAN_HEX_LETTERS_EN
    check("letter_const", 32'({Undefined[0], HexDigits[3:0]}), 32'h0A);
`else
    check("letter_const", 32'({Undefined[0], HexDigits[3:0]}), 32'h1F);
`endif

    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 9) < 7) an = ~(4'b0001 << $urandom_range(0, DIGITS - 1));
      else                          an = 4'($urandom);
      case ($urandom_range(0, 3))
        0:       g = 7'($urandom);
        1:       g = ($urandom_range(0, 1) != 0) ? 7'h7F : 7'h7E;
        default: g = glyph_of[$urandom_range(0, 15)];
      endcase
      len = $urandom_range(1, 6);
      dwell(an, g, len);
      idle(3);
      check_all("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/segment_scan_hex_decoder.md
# segment_scan_hex_decoder

Multi-digit, time-multiplexed seven-segment reverse decoder. It samples a scanned LED display bus (shared segment lines plus per-digit anode enables), qualifies each digit's glyph for stability and decodes it to a 4-bit hex value with blank/undefined flags. It signals frame completion and value changes. It sits between a display-bus snooper/pin interface and logic that needs the numeric value currently shown on a multiplexed display.

## Interface
- `DIGITS`, default 4: number of multiplexed digits, legal range 1..16.
- `STABLE_CYCLES`, default 3: consecutive identical samples required before a capture, legal range 1..255.
- `Clk`, in, 1: single clock; all logic rises on it.
- `nReset`, in, 1: reset, asynchronous, active-low.
- `Segments`, in, 7: active-low segment lines; bit6 = a … bit0 = g.
- `Anodes`, in, DIGITS: active-low digit enables; bit k low selects digit k.
- `HexDigits`, out, 4*DIGITS: decoded value per digit; digit k occupies bits [4k+3:4k].
- `Undefined`, out, DIGITS: digit k's last captured glyph was not a legal glyph, or digit k has never been captured.
- `Blank`, out, DIGITS: digit k's last captured glyph was all segments off (7'b111_1111) or only g lit (7'b111_1110).
- `Valid`, out, 1: at least one complete frame has been captured since reset.
- `FrameStrobe`, out, 1: one-cycle pulse; every digit has been captured since the previous pulse.
- `Changed`, out, 1: one-cycle pulse; a capture altered some digit's {Undefined, Blank, HexDigit}.

## Operation
- Input stage: `Segments` and `Anodes` are registered once. All further logic works on registered samples.
- Legal select: exactly one bit of the registered `Anodes` is low. This yields index k.
  - Zero or multiple low bits count as ghost/idle. The stability counter clears and no capture occurs.
- Stability: counter `cnt` (8 bits).
  - If the sample is legal and {k, Segments} equals the previous registered sample: `cnt` increments, saturating at `STABLE_CYCLES`.
  - Otherwise `cnt` = 1 when legal, 0 when illegal.
  - A capture fires in the cycle `cnt` transitions to `STABLE_CYCLES`, so there is exactly one capture per dwell.
  - With `STABLE_CYCLES`=1, a capture fires on every legal sample whose {k, Segments} differs from the previous sample, and on the first legal sample after an illegal one.
- Decode table (active-low, abcdefg):
  - 0000001 = 0
  - 1001111 = 1
  - 0010010 = 2
  - 0000110 = 3
  - 1001100 = 4
  - 0100100 = 5
  - 0100000 = 6
  - 0001111 = 7
  - 0000000 = 8
  - 0000100 = 9
  - 1111111 or 1111110 → Blank=1, digit 0, Undefined=0.
  - Anything else → Undefined=1, digit 4'hF, Blank=0.
- Capture: writes digit k's {Undefined, Blank, HexDigit} and sets `seen[k]`. If the new triple differs from the old one, `Changed` pulses.
- Frame: when `seen` is all-ones, the next cycle pulses `FrameStrobe`, sets `Valid` (sticky until reset) and clears `seen`.
  - A capture in that same cycle keeps its `seen` bit set; set wins over clear.
- Repeated captures of the same digit within a frame overwrite it; the last one wins.

## Timing
- Reset values: `HexDigits`=0, `Undefined`=all ones, `Blank`=0, `Valid`=0, `FrameStrobe`=0, `Changed`=0, `cnt`=0, `seen`=0, input registers = idle (all ones).
- Latency: inputs stable before edge t are registered at edge t. The digit outputs and `Changed` update at edge t+`STABLE_CYCLES`.
- `FrameStrobe`/`Valid`: asserted one edge after the capture that completes `seen`.
- Pulses are exactly one cycle wide. Back-to-back frames may produce strobes as close as `DIGITS`·`STABLE_CYCLES` cycles apart.
- `nReset` asserted mid-dwell or mid-frame forces all reset values immediately and asynchronously. Deassertion is synchronised externally.

## Configuration
- `SEGMENT_SCAN_HEX_LETTERS_EN` defined: additionally decodes these glyphs, which no longer flag Undefined:
  - 0001000 = A
  - 1100000 = b
  - 0110001 = C
  - 1000010 = d
  - 0110000 = E
  - 0111000 = F
- Undefined still reports 4'hF with Undefined=1, so undefined and a legal F are distinguished only by the flag.
- Not defined: these six glyphs are Undefined (value 4'hF, Undefined=1).

## Test plan
- Reset, then idle bus (Anodes all ones) for 50 cycles → outputs hold reset values; `FrameStrobe` never pulses.
- DIGITS=4, STABLE_CYCLES=3: scan digits 0..3 showing 1,2,3,4, each held 4 cycles → HexDigits=16'h4321, Undefined=0, one `FrameStrobe` after the digit-3 capture, `Valid`=1, `Changed` pulses four times.
- Hold each digit only 2 cycles (< STABLE_CYCLES) → no capture, outputs unchanged, no strobe.
- Repeat an identical frame → `FrameStrobe` pulses, `Changed` stays 0. Then change digit 2 to glyph 1110000 → Undefined[2]=1, digit 2 = F, one `Changed` pulse.
- Drive Anodes=4'b1100 (two low) with a valid glyph for 10 cycles → no capture. Assert `nReset` mid-dwell → all reset values within the same cycle.
- With the macro defined, show 0001000 on digit 0 → digit 0 = 4'hA, Undefined[0]=0. Without the macro, the same stimulus gives digit 0 = F, Undefined[0]=1.
